// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use and branch-operand interlocks,
// multi-cycle multiply/divide hold, post-reset flush and a stall counter.
module pipeline_ctrl #(
  parameter int unsigned MD_LATENCY = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rt_e,
  input  logic             memtoreg_e,
  input  logic             regwrite_e,
  input  logic [4:0]       writereg_e,
  input  logic             memtoreg_m,
  input  logic [4:0]       writereg_m,
  input  logic             branch_d,
  input  logic             branch_taken_d,
  input  logic             md_start_e,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             clr_d,
  output logic             clr_e,
  output logic             clr_m,
  output logic             clr_w,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {INIT, RUN, MDWAIT} state_t;

  localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

  state_t     state, state_next;
  logic       init_cnt;
  logic [7:0] md_cnt;
  logic       lwstall, brstall, stall;
  logic       count_stall;

  always_comb begin
    lwstall = memtoreg_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));
    brstall = branch_d &&
              ((regwrite_e && (writereg_e != '0) &&
                ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
               (memtoreg_m && (writereg_m != '0) &&
                ((writereg_m == rs_d) || (writereg_m == rt_d))));
    stall   = lwstall || brstall;
  end

  // Reset gates the outputs directly so INIT values show even before the first edge.
  always_comb begin
    state_next = state;
    en_f    = 1'b0;
    en_d    = 1'b0;
    en_e    = 1'b0;
    clr_d   = 1'b1;
    clr_e   = 1'b1;
    clr_m   = 1'b1;
    clr_w   = 1'b1;
    md_busy = 1'b0;
    if (!reset) begin
      case (state)
        INIT: begin
          if (init_cnt) state_next = RUN;
        end
        RUN: begin
          en_f  = ~stall;
          en_d  = ~stall;
          en_e  = 1'b1;
          clr_d = branch_taken_d && !stall;
          clr_e = stall;
          clr_m = 1'b0;
          clr_w = 1'b0;
          if (md_start_e && !stall) state_next = MDWAIT;
        end
        MDWAIT: begin
          clr_d   = 1'b0;
          clr_e   = 1'b0;
          clr_w   = 1'b0;
          md_busy = 1'b1;
          if (md_cnt == 8'd1) state_next = RUN;
        end
        default: state_next = INIT;
      endcase
    end
  end

  assign count_stall = ((state == RUN) || (state == MDWAIT)) && !en_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= 1'b0;
      md_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_next;
      init_cnt <= (state == INIT) && !init_cnt;
      if ((state == RUN) && (state_next == MDWAIT))
        md_cnt <= MD_LOAD;
      else if (state == MDWAIT)
        md_cnt <= md_cnt - 8'd1;
      if (count_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl: single-cycle hazard table plus
// multiply/divide, reset-during-MDWAIT and counter saturation sequences.
module tb_pipeline_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rt_e, writereg_e, writereg_m;
  logic       memtoreg_e, regwrite_e, memtoreg_m, branch_d, branch_taken_d, md_start_e;

  logic        en_f, en_d, en_e, clr_d, clr_e, clr_m, clr_w, md_busy;
  logic [15:0] stall_cnt;
  logic        en_f4, en_d4, en_e4, clr_d4, clr_e4, clr_m4, clr_w4, md_busy4;
  logic [3:0]  stall_cnt4;
  logic [7:0]  ctrl;

  // {en_f, en_d, en_e, clr_d, clr_e, clr_m, clr_w, md_busy}
  localparam logic [7:0] C_INIT  = 8'b0001_1110;
  localparam logic [7:0] C_RUN   = 8'b1110_0000;
  localparam logic [7:0] C_STALL = 8'b0010_1000;
  localparam logic [7:0] C_FLUSH = 8'b1111_0000;
  localparam logic [7:0] C_MDW   = 8'b0000_0101;

  typedef struct {
    logic [4:0]  rs, rt, rte;
    logic        mte, rwe;
    logic [4:0]  wre;
    logic        mtm;
    logic [4:0]  wrm;
    logic        br, bt, md;
    logic [7:0]  ctrl;
    logic [15:0] cnt;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt;
  vec_t vecs[13];
  vec_t idle_v, lw_v;

  pipeline_ctrl #(.MD_LATENCY(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rt_e(rt_e),
    .memtoreg_e(memtoreg_e), .regwrite_e(regwrite_e), .writereg_e(writereg_e),
    .memtoreg_m(memtoreg_m), .writereg_m(writereg_m), .branch_d(branch_d),
    .branch_taken_d(branch_taken_d), .md_start_e(md_start_e),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .clr_d(clr_d), .clr_e(clr_e),
    .clr_m(clr_m), .clr_w(clr_w), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.MD_LATENCY(8), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rt_e(rt_e),
    .memtoreg_e(memtoreg_e), .regwrite_e(regwrite_e), .writereg_e(writereg_e),
    .memtoreg_m(memtoreg_m), .writereg_m(writereg_m), .branch_d(branch_d),
    .branch_taken_d(branch_taken_d), .md_start_e(md_start_e),
    .en_f(en_f4), .en_d(en_d4), .en_e(en_e4), .clr_d(clr_d4), .clr_e(clr_e4),
    .clr_m(clr_m4), .clr_w(clr_w4), .md_busy(md_busy4), .stall_cnt(stall_cnt4)
  );

  assign ctrl = {en_f, en_d, en_e, clr_d, clr_e, clr_m, clr_w, md_busy};

  always #5 clock = ~clock;

  function automatic vec_t mk(input int rs, input int rt, input int rte, input int mte,
                              input int rwe, input int wre, input int mtm, input int wrm,
                              input int br, input int bt, input int md,
                              input logic [7:0] c, input int cnt);
    vec_t v;
    v.rs = 5'(rs);  v.rt = 5'(rt);  v.rte = 5'(rte);
    v.mte = (mte != 0);  v.rwe = (rwe != 0);  v.wre = 5'(wre);
    v.mtm = (mtm != 0);  v.wrm = 5'(wrm);
    v.br = (br != 0);  v.bt = (bt != 0);  v.md = (md != 0);
    v.ctrl = c;  v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rs_d = v.rs;  rt_d = v.rt;  rt_e = v.rte;
    memtoreg_e = v.mte;  regwrite_e = v.rwe;  writereg_e = v.wre;
    memtoreg_m = v.mtm;  writereg_m = v.wrm;
    branch_d = v.br;  branch_taken_d = v.bt;  md_start_e = v.md;
  endtask

  // Samples at the falling edge, then advances to just after the next rising edge.
  // exp_cnt4 < 0 skips the narrow-counter comparison.
  task automatic check(input string name, input logic [7:0] exp_ctrl,
                       input int exp_c, input int exp_cnt4);
    @(negedge clock);
    vectors++;
    if (ctrl !== exp_ctrl || stall_cnt !== 16'(exp_c)) begin
      miscompares++;
      $display("FAIL %s: ctrl=%b required %b, stall_cnt=%0d required %0d",
               name, ctrl, exp_ctrl, stall_cnt, exp_c);
    end
    if (exp_cnt4 >= 0) begin
      vectors++;
      if (stall_cnt4 !== 4'(exp_cnt4)) begin
        miscompares++;
        $display("FAIL %s_w4: stall_cnt=%0d required %0d", name, stall_cnt4, exp_cnt4);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    //           rs rt rte mte rwe wre mtm wrm br bt md  ctrl     cnt
    vecs[0]  = mk(0, 0, 0,  0,  0,  0,  0,  0,  0, 0, 0, C_RUN,   0);
    vecs[1]  = mk(5, 0, 5,  1,  0,  0,  0,  0,  0, 0, 0, C_STALL, 0);
    vecs[2]  = mk(0, 0, 0,  1,  0,  0,  0,  0,  0, 0, 0, C_RUN,   1);
    vecs[3]  = mk(3, 9, 9,  1,  0,  0,  0,  0,  0, 0, 0, C_STALL, 1);
    vecs[4]  = mk(3, 9, 9,  0,  0,  0,  0,  0,  0, 0, 0, C_RUN,   2);
    vecs[5]  = mk(0, 7, 0,  0,  1,  7,  0,  0,  1, 1, 0, C_STALL, 2);
    vecs[6]  = mk(0, 7, 0,  0,  0,  7,  0,  0,  1, 1, 0, C_FLUSH, 3);
    vecs[7]  = mk(4, 0, 0,  0,  0,  0,  1,  4,  1, 0, 0, C_STALL, 3);
    vecs[8]  = mk(0, 0, 0,  0,  1,  0,  0,  0,  1, 1, 0, C_FLUSH, 4);
    vecs[9]  = mk(0, 7, 0,  0,  1,  7,  0,  0,  0, 0, 0, C_RUN,   4);
    vecs[10] = mk(0, 0, 0,  0,  0,  0,  1,  0,  1, 1, 0, C_FLUSH, 4);
    vecs[11] = mk(5, 5, 0,  0,  1,  6,  0,  0,  1, 1, 0, C_FLUSH, 4);
    vecs[12] = mk(5, 0, 5,  1,  0,  0,  0,  0,  1, 1, 0, C_STALL, 4);
    idle_v   = mk(0, 0, 0,  0,  0,  0,  0,  0,  0, 0, 0, C_RUN,   0);
    lw_v     = mk(5, 0, 5,  1,  0,  0,  0,  0,  0, 0, 0, C_STALL, 0);

    reset = 1'b1;
    drive(idle_v);
    @(posedge clock);
    #1;
    check("reset_held", C_INIT, 0, 0);
    reset = 1'b0;
    check("init1", C_INIT, 0, 0);
    check("init2", C_INIT, 0, 0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i].ctrl, int'(vecs[i].cnt), -1);
    end
    exp_cnt = 5;

    // md_start blocked by a load-use stall must not enter MDWAIT
    drive(lw_v);
    md_start_e = 1'b1;
    check("md_stalled", C_STALL, exp_cnt, -1);
    exp_cnt++;
    drive(idle_v);
    check("md_stalled_next", C_RUN, exp_cnt, -1);

    drive(idle_v);
    md_start_e = 1'b1;
    check("md_start", C_RUN, exp_cnt, -1);
    // hazards and taken branches present during MDWAIT must be ignored
    drive(vecs[12]);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("mdwait%0d", i), C_MDW, exp_cnt, -1);
      exp_cnt++;
    end
    drive(idle_v);
    check("md_done", C_RUN, exp_cnt, -1);

    md_start_e = 1'b1;
    check("md_start2", C_RUN, exp_cnt, -1);
    md_start_e = 1'b0;
    check("md2_c1", C_MDW, exp_cnt, -1);
    exp_cnt++;
    check("md2_c2", C_MDW, exp_cnt, -1);
    exp_cnt++;
    reset = 1'b1;
    check("md2_c3_reset", C_INIT, exp_cnt, -1);
    reset = 1'b0;
    check("post_rst1", C_INIT, 0, 0);
    check("post_rst2", C_INIT, 0, 0);
    check("post_rst_run", C_RUN, 0, 0);

    drive(lw_v);
    for (int i = 0; i < 20; i++)
      check($sformatf("sat%0d", i), C_STALL, i, (i > 15) ? 15 : i);
    drive(idle_v);
    check("sat_hold", C_RUN, 20, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 8: cycles a multiply/divide holds the Execute stage (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clock  in  1  single clock; all state updates on posedge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rs_d, rt_d  in  5 each  source register numbers of the Decode-stage instruction.
REQ-006 rt_e  in  5  rt of the Execute-stage instruction; memtoreg_e  in  1  Execute instruction is a load.
REQ-007 regwrite_e  in  1; writereg_e  in  5  Execute-stage destination register and write flag.
REQ-008 memtoreg_m  in  1; writereg_m  in  5  Memory-stage load flag and destination register.
REQ-009 branch_d  in  1  Decode instruction is a branch; branch_taken_d  in  1  branch resolved taken in Decode.
REQ-010 md_start_e  in  1  Execute-stage instruction is a multiply/divide (level, sampled in RUN only).
REQ-011 en_f, en_d, en_e  out  1 each  enables for PC, IF/ID and ID/EX pipeline registers.
REQ-012 clr_d, clr_e, clr_m, clr_w  out  1 each  synchronous clears for IF/ID, ID/EX, EX/MEM, MEM/WB registers.
REQ-013 md_busy  out  1  multiply/divide sequence in progress; stall_cnt  out  CNT_W  stall cycle count.

Function
REQ-014 SHALL implement states INIT, RUN, MDWAIT in a registered state variable; outputs are combinational from state and inputs.
REQ-015 lwstall SHALL = memtoreg_e & (rt_e != 0) & (rt_e == rs_d | rt_e == rt_d).
REQ-016 brstall SHALL = branch_d & ((regwrite_e & writereg_e != 0 & writereg_e matches rs_d or rt_d) | (memtoreg_m & writereg_m != 0 & writereg_m matches rs_d or rt_d)).
REQ-017 Register 0 SHALL never produce a hazard.
REQ-018 INIT: en_f = en_d = en_e = 0; clr_d = clr_e = clr_m = clr_w = 1; lasts exactly 2 cycles (internal counter), then RUN.
REQ-019 RUN, stall = lwstall | brstall: en_f = en_d = ~stall; en_e = 1; clr_e = stall; clr_m = clr_w = 0.
REQ-020 RUN: clr_d = branch_taken_d & ~stall; a stall SHALL take priority over a branch flush in the same cycle.
REQ-021 RUN with md_start_e = 1 and stall = 0: next state MDWAIT, counter loaded with MD_LATENCY-1; the current cycle behaves as a normal RUN cycle.
REQ-022 RUN with md_start_e = 1 and stall = 1: stay in RUN; md_start_e re-evaluated next cycle.
REQ-023 MDWAIT: en_f = en_d = en_e = 0; clr_m = 1 (bubble into Memory); clr_d = clr_e = clr_w = 0; hazard and branch inputs ignored; md_busy = 1.
REQ-024 MDWAIT: counter decrements each cycle; when counter == 1 next state RUN; total MDWAIT residency = MD_LATENCY-1 cycles.
REQ-025 md_busy SHALL be 0 in INIT and RUN.
REQ-026 stall_cnt SHALL increment by 1 on every cycle in which en_d = 0 in RUN or MDWAIT, saturating at all-ones (no wrap); INIT cycles not counted.

Reset
REQ-027 reset = 1 at a clock edge SHALL force state INIT, INIT counter 0, MD counter 0, stall_cnt 0, from any state including mid-MDWAIT.
REQ-028 While reset is high, outputs SHALL show INIT values (all enables 0, all clears 1, md_busy 0).
REQ-029 After reset deasserts, 2 INIT cycles SHALL elapse before the first RUN cycle.

Verification
REQ-030 Reset then idle inputs -> 2 cycles all clears 1 / enables 0, then en_f = en_d = en_e = 1, all clears 0, stall_cnt = 0.
REQ-031 RUN, memtoreg_e = 1, rt_e = 5, rs_d = 5 -> en_f = en_d = 0, clr_e = 1, stall_cnt +1; same with rt_e = 0 -> no stall.
REQ-032 RUN, branch_d = 1, branch_taken_d = 1, regwrite_e = 1, writereg_e = rt_d = 7 -> stall, clr_d = 0; next cycle, hazard gone -> clr_d = 1, en_d = 1.
REQ-033 MD_LATENCY = 8, md_start_e = 1 in RUN, no hazard -> exactly 7 cycles md_busy = 1, en_e = 0, clr_m = 1, then RUN; stall_cnt +7.
REQ-034 reset asserted in 3rd MDWAIT cycle -> next cycle INIT outputs, md_busy = 0, stall_cnt = 0.
REQ-035 CNT_W = 4, continuous load-use stall for 20 cycles -> stall_cnt holds 15, does not wrap.
